// File: rtl/i2c_cfg_arbiter.sv
// Arbitrates a fixed 5-entry boot table and single host writes onto one I2C
// byte-write engine, with NACK retries and an enforced idle gap between transfers.
module i2c_cfg_arbiter #(
    parameter logic [6:0]  C_I2C_SLAVE_ADDR = 7'b1110110,
    parameter int unsigned GAP_CYCLES       = 375,
    parameter int unsigned MAX_RETRY        = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Reinit,
    input  logic       Host_req,
    input  logic [7:0] Host_reg,
    input  logic [7:0] Host_data,
    output logic       Host_ack,
    output logic       Host_err,
    output logic       Xfer_start,
    output logic [6:0] Xfer_slave,
    output logic [7:0] Xfer_reg,
    output logic [7:0] Xfer_data,
    input  logic       Xfer_done,
    input  logic       Xfer_nack,
    output logic       Boot_done,
    output logic       Boot_err,
    output logic       Busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    localparam int              GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]      RETRY_LIM  = 3'(MAX_RETRY);
    localparam logic [2:0]      LAST_ENTRY = 3'd4;

    state_t           state;
    logic [2:0]       boot_ptr;
    logic [2:0]       retry_cnt;
    logic             boot_pend;
    logic             reinit_flag;
    logic             is_host;
    logic             redo;
    logic [GAP_W-1:0] gap_cnt;

    function automatic logic [15:0] boot_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    boot_entry = 16'h49C0;
            3'd1:    boot_entry = 16'h2109;
            3'd2:    boot_entry = 16'h3308;
            3'd3:    boot_entry = 16'h3416;
            3'd4:    boot_entry = 16'h3660;
            default: boot_entry = 16'h0000;
        endcase
    endfunction

    assign Xfer_slave = C_I2C_SLAVE_ADDR;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            boot_ptr    <= 3'd0;
            retry_cnt   <= 3'd0;
            boot_pend   <= 1'b1;
            reinit_flag <= 1'b0;
            is_host     <= 1'b0;
            redo        <= 1'b0;
            gap_cnt     <= '0;
            Xfer_start  <= 1'b0;
            Xfer_reg    <= 8'h00;
            Xfer_data   <= 8'h00;
            Host_ack    <= 1'b0;
            Host_err    <= 1'b0;
            Boot_done   <= 1'b0;
            Boot_err    <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            Xfer_start <= 1'b0;
            Host_ack   <= 1'b0;
            Host_err   <= 1'b0;
            if (Reinit) begin
                reinit_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // A pending retry re-issues the held entry before any new arbitration.
                    if (redo) begin
                        redo       <= 1'b0;
                        Xfer_start <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= ISSUE;
                    end else if (reinit_flag || Reinit) begin
                        reinit_flag            <= 1'b0;
                        boot_ptr               <= 3'd0;
                        boot_pend              <= 1'b1;
                        Boot_done              <= 1'b0;
                        Boot_err               <= 1'b0;
                        is_host                <= 1'b0;
                        {Xfer_reg, Xfer_data}  <= boot_entry(3'd0);
                        Xfer_start             <= 1'b1;
                        Busy                   <= 1'b1;
                        state                  <= ISSUE;
                    end else if (boot_pend) begin
                        is_host                <= 1'b0;
                        {Xfer_reg, Xfer_data}  <= boot_entry(boot_ptr);
                        Xfer_start             <= 1'b1;
                        Busy                   <= 1'b1;
                        state                  <= ISSUE;
                    end else if (Host_req) begin
                        is_host    <= 1'b1;
                        Xfer_reg   <= Host_reg;
                        Xfer_data  <= Host_data;
                        Xfer_start <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    if (Xfer_done) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                        if (Xfer_nack && (retry_cnt < RETRY_LIM)) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            redo      <= 1'b1;
                        end else begin
                            retry_cnt <= 3'd0;
                            if (is_host) begin
                                Host_ack <= 1'b1;
                                Host_err <= Xfer_nack;
                            end else begin
                                // Failed boot entries are recorded but the table still advances.
                                if (Xfer_nack) begin
                                    Boot_err <= 1'b1;
                                end
                                boot_ptr <= boot_ptr + 3'd1;
                                if (boot_ptr == LAST_ENTRY) begin
                                    Boot_done <= 1'b1;
                                    boot_pend <= 1'b0;
                                end
                            end
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_cfg_arbiter.md
I2C_CFG_ARBITER -- requirements
Module: i2c_cfg_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- C_I2C_SLAVE_ADDR, 7'b1110110, slave address driven on Xfer_slave.
- GAP_CYCLES, 375, idle Clk cycles between consecutive transfers.
- MAX_RETRY, 3, re-issues allowed after a NACK (range 0..7).

REQ-002 Ports SHALL be as follows, one per line:
- Clk  in  1  sole clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Reinit  in  1  one-cycle pulse; re-runs the boot table.
- Host_req  in  1  level; host single-write request.
- Host_reg  in  8  host register address; held stable until Host_ack.
- Host_data  in  8  host write data; held stable until Host_ack.
- Host_ack  out  1  one-cycle pulse; host write finished.
- Host_err  out  1  valid with Host_ack; retries exhausted.
- Xfer_start  out  1  one-cycle pulse to the I2C byte-write engine.
- Xfer_slave  out  7  equals C_I2C_SLAVE_ADDR.
- Xfer_reg  out  8  register address for the engine.
- Xfer_data  out  8  data byte for the engine.
- Xfer_done  in  1  one-cycle pulse; engine finished.
- Xfer_nack  in  1  valid with Xfer_done; slave did not ACK.
- Boot_done  out  1  boot table completed.
- Boot_err  out  1  sticky; at least one boot entry failed.
- Busy  out  1  high in any state other than IDLE.

Function
REQ-003 The block SHALL contain a fixed 5-entry boot table of {reg,data} pairs: 0:{49,C0} 1:{21,09} 2:{33,08} 3:{34,16} 4:{36,60} (hex).
REQ-004 The state machine SHALL have exactly these states: IDLE, ISSUE, WAIT, GAP.
REQ-005 IDLE SHALL arbitrate as follows:
- If boot is pending, go to ISSUE with the boot entry at boot_ptr.
- Otherwise, if Host_req=1, latch Host_reg/Host_data and go to ISSUE.
- Otherwise, stay in IDLE.
- Boot SHALL always win over host.
REQ-006 ISSUE SHALL last exactly 1 cycle with Xfer_start=1, then go to WAIT; Xfer_start SHALL be 0 in all other states.
REQ-007 Xfer_reg/Xfer_data SHALL be registered and SHALL remain stable from ISSUE through the end of WAIT.
REQ-008 WAIT SHALL hold until Xfer_done=1.
- On Xfer_nack=1 with retry_cnt<MAX_RETRY: increment retry_cnt, go to GAP, then reissue the same entry.
- Otherwise: clear retry_cnt, mark the entry complete, go to GAP.
REQ-009 Xfer_done SHALL be ignored outside WAIT.
REQ-010 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE.
REQ-011 Boot completion SHALL behave as follows:
- Completing a boot entry increments boot_ptr.
- A failed entry (NACK with retries exhausted) sets Boot_err=1 and the table still advances.
- After entry 4 completes, Boot_done=1 and boot is no longer pending.
REQ-012 Host completion SHALL pulse Host_ack=1 for one cycle on the WAIT->GAP transition, with Host_err=1 in that same cycle if retries were exhausted, else Host_err=0.
REQ-013 If Host_req is deasserted before it is latched, no transfer SHALL occur; once latched, the transfer SHALL complete and Host_ack SHALL pulse regardless of Host_req.
REQ-014 Reinit SHALL be captured into a pending flag in any state. The flag SHALL be applied only in IDLE: boot_ptr=0, Boot_done=0, Boot_err=0, boot pending=1. An in-flight transfer SHALL NOT be aborted.
REQ-015 If Reinit and Host_req are both present in IDLE, Reinit SHALL be applied first and boot SHALL win. The host request waits and is unaffected.
REQ-016 No transfer SHALL start within GAP_CYCLES cycles after the previous Xfer_done.

Reset
REQ-017 While Reset=1, the block SHALL force the following asynchronously:
- State IDLE; boot_ptr=0; retry_cnt=0; boot pending=1; Reinit flag=0.
- All outputs 0, except Xfer_slave=C_I2C_SLAVE_ADDR.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer. After release, the first Xfer_start SHALL carry boot entry 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset release, engine model ACKs everything -> 5 Xfer_start pulses carrying {49,C0},{21,09},{33,08},{34,16},{36,60}, each >=GAP_CYCLES apart; Boot_done=1, Boot_err=0.
- Entry 2 NACKs 4 times (MAX_RETRY=3) -> 4 starts with {33,08}; Boot_err=1; entries 3 and 4 still sent; Boot_done=1.
- Host_req with {0A,5F} asserted during boot -> Host write issued only after entry 4's GAP; one Host_ack pulse with Host_err=0.
- Reinit pulse during host WAIT -> host write completes with Host_ack; next start is {49,C0}; Boot_done low until the table finishes.
- Reset pulse during WAIT of entry 3 -> outputs cleared immediately; next start after release is {49,C0}.
- Spurious Xfer_done in GAP or IDLE -> no state change, no retry, no Host_ack.
